// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline hazard/stall controller for the 5-stage RV32I core
//
// Handles the hazards the forwarding unit cannot resolve. These are load-use bubbles,
// taken-branch flushes, and a whole-pipe freeze while data memory is busy. A freeze that
// runs too long latches a sticky timeout. The stall and flush outputs are combinational
// from the inputs and the current state. The counters and the state update one cycle later.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   readReg1_ID/readReg2_ID           rs1/rs2 of the ID instruction
//   usesRs1_ID/usesRs2_ID             ID instruction really reads rs1/rs2
//   addwriteReg_EX, memRead_EX        rd of the EX instruction, EX is a load
//   branchTaken_EX                    EX resolved a taken branch/jump
//   memReq_MEM, memReady_MEM          MEM access pending / completing
//   stall_PC/IFID/IDEX/EXMEM          hold enables
//   flush_IFID/IDEX/MEMWB             bubble enables
//   memTimeout                        sticky memory-wait timeout
//   stallCount, flushCount            saturating perf counters
module hazard_stall_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       readReg1_ID,
  input  logic [4:0]       readReg2_ID,
  input  logic             usesRs1_ID,
  input  logic             usesRs2_ID,
  input  logic [4:0]       addwriteReg_EX,
  input  logic             memRead_EX,
  input  logic             branchTaken_EX,
  input  logic             memReq_MEM,
  input  logic             memReady_MEM,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             stall_IDEX,
  output logic             stall_EXMEM,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_MEMWB,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;

  logic freeze, load_use;
  logic frz_out, run_rules, branch_flush;
  logic s_pc, s_ifid, f_ifid, f_idex;

  assign freeze   = memReq_MEM & ~memReady_MEM;
  assign load_use = memRead_EX && (addwriteReg_EX != 5'd0) &&
                    ((usesRs1_ID && (readReg1_ID == addwriteReg_EX)) ||
                     (usesRs2_ID && (readReg2_ID == addwriteReg_EX)));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    frz_out      = 1'b0;
    run_rules    = 1'b0;
    branch_flush = 1'b0;
    s_pc         = 1'b0;
    s_ifid       = 1'b0;
    f_ifid       = 1'b0;
    f_idex       = 1'b0;

    case (state_q)
      S_RUN: begin
        if (freeze) begin
          frz_out    = 1'b1;
          wait_cnt_d = WC_W'(1);
          state_d    = S_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      S_WAIT: begin
        if (freeze) begin
          frz_out = 1'b1;
          if (wait_cnt_q == WC_W'(MAX_WAIT - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          // Ready or a withdrawn request releases the pipe in the same cycle.
          run_rules  = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_RUN;
        end
      end
      S_ERROR: frz_out = 1'b1;
      default: state_d = S_RUN;
    endcase

    // A taken branch wins over load-use because the ID instruction is discarded anyway.
    if (run_rules) begin
      if (branchTaken_EX) begin
        branch_flush = 1'b1;
        f_ifid       = 1'b1;
        f_idex       = 1'b1;
      end else if (load_use) begin
        s_pc   = 1'b1;
        s_ifid = 1'b1;
        f_idex = 1'b1;
      end
    end

    if (frz_out) begin
      s_pc   = 1'b1;
      s_ifid = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (s_pc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Gated by rst_n so that outputs drop at once on reset, even while the inputs still request a freeze.
  assign stall_PC    = rst_n & s_pc;
  assign stall_IFID  = rst_n & s_ifid;
  assign stall_IDEX  = rst_n & frz_out;
  assign stall_EXMEM = rst_n & frz_out;
  assign flush_IFID  = rst_n & f_ifid;
  assign flush_IDEX  = rst_n & f_idex;
  assign flush_MEMWB = rst_n & frz_out;
  assign memTimeout  = timeout_q;
  assign stallCount  = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule
